// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed 7-segment scan controller with blank guard and tear-free updates
// Rotates one shared hex decoder over NUM_DIGITS common-anode digits; all outputs registered.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic                      lz_en,
    output logic [3:0]                hex_nibble,
    output logic [NUM_DIGITS-1:0]     digit_en_L,
    output logic                      frame_tick
);

    localparam int MAX_CYC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int DIG_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIG_W-1:0]          digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic                      pending_valid_q, pending_valid_d;
    logic [3:0]                hex_nibble_q, hex_nibble_d;
    logic [NUM_DIGITS-1:0]     digit_en_L_q, digit_en_L_d;
    logic                      frame_tick_q, frame_tick_d;
    logic                      wrap;

    // Digit k is blank when lz is on, k>0 and nibbles k..NUM_DIGITS-1 are all zero.
    function automatic logic is_suppressed(input logic [4*NUM_DIGITS-1:0] word,
                                           input logic [DIG_W-1:0]        k,
                                           input logic                    lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(k) && word[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        return lz && (k != '0) && upper_zero;
    endfunction

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        digit_d         = digit_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        wrap            = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (digit_q == DIG_LAST) begin
                        digit_d = '0;
                        wrap    = 1'b1;
                    end else begin
                        digit_d = digit_q + DIG_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // The displayed word only moves at the frame wrap, so a frame never mixes two values.
        if (wrap) begin
            if (load) begin
                active_d = value;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = value;
            pending_valid_d = 1'b1;
        end

        frame_tick_d = wrap;
        hex_nibble_d = active_d[{digit_d, 2'b00} +: 4];

        // Anode decision is taken once on SHOW entry and held, so lz_en changes never cut a slot short.
        if (state_d == ST_BLANK) begin
            digit_en_L_d = '1;
        end else if (state_q == ST_BLANK) begin
            if (is_suppressed(active_d, digit_d, lz_en)) begin
                digit_en_L_d = '1;
            end else begin
                digit_en_L_d = ~(NUM_DIGITS'(1) << digit_d);
            end
        end else begin
            digit_en_L_d = digit_en_L_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_BLANK;
            cnt_q           <= '0;
            digit_q         <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            hex_nibble_q    <= 4'h0;
            digit_en_L_q    <= '1;
            frame_tick_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            digit_q         <= digit_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            hex_nibble_q    <= hex_nibble_d;
            digit_en_L_q    <= digit_en_L_d;
            frame_tick_q    <= frame_tick_d;
        end
    end

    assign hex_nibble = hex_nibble_q;
    assign digit_en_L = digit_en_L_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed and random checks of seven_seg_scan_ctrl against a frame-position model
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int B     = 2;
    localparam int O     = 4;
    localparam int SLOT  = B + O;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  hex_nibble;
    logic [3:0]  digit_en_L;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    // Reference: cycle index since reset plus the word registers, everything else derived arithmetically.
    int          mt = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;
    logic        m_pv = 1'b0;
    logic        m_lz = 1'b0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .BLANK_CYCLES(B),
        .ON_CYCLES   (O)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .lz_en     (lz_en),
        .hex_nibble(hex_nibble),
        .digit_en_L(digit_en_L),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, mt, got, exp);
        end
    endtask

    task automatic check_model();
        int          pos;
        int          d;
        logic        blank;
        logic        supp;
        logic [15:0] upper;
        logic [3:0]  e_en;
        logic [3:0]  e_hex;
        pos   = mt % FRAME;
        d     = pos / SLOT;
        blank = (pos % SLOT) < B;
        upper = m_active >> (4 * d);
        supp  = m_lz && (d > 0) && (upper == 16'h0);
        e_hex = 4'((m_active >> (4 * d)) & 16'hF);
        if (blank || supp) e_en = 4'hF;
        else               e_en = ~(4'b0001 << d);
        chk("model_hex",  32'(hex_nibble), 32'(e_hex));
        chk("model_en",   32'(digit_en_L), 32'(e_en));
        chk("model_tick", 32'(frame_tick), 32'((mt > 0) && (pos == 0)));
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic lz);
        int pos;
        rst   = r;
        load  = ld;
        value = v;
        lz_en = lz;
        if (r) begin
            mt        = 0;
            m_active  = '0;
            m_pending = '0;
            m_pv      = 1'b0;
        end else begin
            pos = mt % FRAME;
            if (pos == FRAME - 1) begin
                if (ld)        m_active = v;
                else if (m_pv) m_active = m_pending;
                m_pv = 1'b0;
            end else if (ld) begin
                m_pending = v;
                m_pv      = 1'b1;
            end
            if ((pos % SLOT) == B - 1) m_lz = lz;
            mt++;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run_to(input int target, input logic lz);
        while (mt < target) step(1'b0, 1'b0, 16'h0, lz);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        // 1: idle scan after reset
        do_reset();
        chk("rst_en", 32'(digit_en_L), 32'hF);
        chk("rst_hex", 32'(hex_nibble), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        run_to(2, 1'b0);
        chk("t1_show0", 32'(digit_en_L), 32'hE);
        run_to(6, 1'b0);
        chk("t1_blank", 32'(digit_en_L), 32'hF);
        run_to(8, 1'b0);
        chk("t1_show1", 32'(digit_en_L), 32'hD);

        // 2: load at cycle 0 appears only after the first wrap
        do_reset();
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        run_to(20, 1'b0);
        chk("t2_frame0", 32'(hex_nibble), 32'h0);
        run_to(26, 1'b0);
        chk("t2_d0_hex", 32'(hex_nibble), 32'h4);
        chk("t2_d0_en", 32'(digit_en_L), 32'hE);
        run_to(44, 1'b0);
        chk("t2_d3_hex", 32'(hex_nibble), 32'h1);
        chk("t2_d3_en", 32'(digit_en_L), 32'h7);

        // 3: last load in a frame wins
        do_reset();
        run_to(5, 1'b0);
        step(1'b0, 1'b1, 16'hAAAA, 1'b0);
        run_to(15, 1'b0);
        step(1'b0, 1'b1, 16'h00B7, 1'b0);
        run_to(26, 1'b0);
        chk("t3_d0", 32'(hex_nibble), 32'h7);
        run_to(32, 1'b0);
        chk("t3_d1", 32'(hex_nibble), 32'hB);
        run_to(38, 1'b0);
        chk("t3_d2", 32'(hex_nibble), 32'h0);

        // 4: leading-zero suppression, then an all-zero word
        do_reset();
        step(1'b0, 1'b1, 16'h0050, 1'b1);
        run_to(32, 1'b1);
        chk("t4_d1_en", 32'(digit_en_L), 32'hD);
        chk("t4_d1_hex", 32'(hex_nibble), 32'h5);
        run_to(38, 1'b1);
        chk("t4_d2_en", 32'(digit_en_L), 32'hF);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        run_to(44, 1'b1);
        chk("t4_d3_en", 32'(digit_en_L), 32'hF);
        run_to(50, 1'b1);
        chk("t4_zero_d0", 32'(digit_en_L), 32'hE);
        run_to(56, 1'b1);
        chk("t4_zero_d1", 32'(digit_en_L), 32'hF);

        // 5: frame_tick placement over three frames
        do_reset();
        run_to(24, 1'b0);
        chk("t5_tick24", 32'(frame_tick), 32'h1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t5_tick25", 32'(frame_tick), 32'h0);
        run_to(48, 1'b0);
        chk("t5_tick48", 32'(frame_tick), 32'h1);
        run_to(72, 1'b0);

        // 6: reset in SHOW of digit 2 with a pending load
        do_reset();
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        run_to(30, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        run_to(38, 1'b0);
        chk("t6_pre_en", 32'(digit_en_L), 32'hB);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t6_rst_en", 32'(digit_en_L), 32'hF);
        chk("t6_rst_hex", 32'(hex_nibble), 32'h0);
        run_to(26, 1'b0);
        chk("t6_after_d0", 32'(hex_nibble), 32'h0);
        run_to(44, 1'b0);
        chk("t6_after_d3", 32'(hex_nibble), 32'h0);

        // Random loads, lz toggles and occasional resets
        begin
            logic lz_r;
            lz_r = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
                if ($urandom_range(0, 399) == 0)
                    step(1'b1, 1'b0, 16'h0, lz_r);
                else
                    step(1'b0, $urandom_range(0, 14) == 0,
                         ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                         lz_r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
